// File: rtl/serial_subtractor_borrowing.sv
`default_nettype none
// ============================================================================
// serial_subtractor_borrowing
// Bit-serial {borrow_out, diff} = a - b - b_in, LSB first, one bit per cycle.
// Option macro: SERIAL_SUBTRACTOR_B2B_EN (accept next operands while emitting)
// Revision: 1.0
// ============================================================================
module serial_subtractor_borrowing #(
  parameter int INPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_SIZE-1:0] a,
  input  logic [INPUT_SIZE-1:0] b,
  input  logic                  b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] diff,
  output logic                  borrow_out
);

  // One extra counter bit keeps the N=1 build from collapsing to zero width.
  localparam int              CW       = $clog2(INPUT_SIZE) + 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [INPUT_SIZE-1:0]   a_q, a_d;
  logic [INPUT_SIZE-1:0]   b_q, b_d;
  logic [INPUT_SIZE-1:0]   diff_q, diff_d;
  logic                    br_q, br_d;
  logic                    bout_q, bout_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    w_load;
  logic                    w_bit;
  logic                    w_borrow;
  logic [INPUT_SIZE-1:0]   w_diff_shift;

  assign w_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign w_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  generate
    if (INPUT_SIZE == 1) begin : g_diff_one
      assign w_diff_shift = w_bit;
    end else begin : g_diff_wide
      assign w_diff_shift = {w_bit, diff_q[INPUT_SIZE-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    br_d      = br_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    w_load    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        w_load   = in_valid;
      end
      BUSY: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = w_diff_shift;
        br_d   = w_borrow;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          bout_d  = w_borrow;
        end
      end
      DONE: begin
`ifdef SERIAL_SUBTRACTOR_B2B_EN
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
          w_load  = in_valid;
        end
`else
        if (out_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // diff/borrow_out are left alone on load so a finished result stays visible.
    if (w_load) begin
      a_d     = a;
      b_d     = b;
      br_d    = b_in;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_borrowing.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor_borrowing
// Directed bench for the N=8 and N=1 builds of the serial subtractor.
// Revision: 1.0
// ============================================================================
module tb_serial_subtractor_borrowing;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv8 = 1'b0, or8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, bo8;
  logic [7:0] d8;

  logic       iv1 = 1'b0, or1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ir1, ov1, bo1;
  logic [0:0] d1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor_borrowing #(.INPUT_SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .b_in(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8)
  );

  serial_subtractor_borrowing #(.INPUT_SIZE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .b_in(bin1), .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1)
  );

  // Offer operands to the N=8 DUT (assumed idle) and wait for out_valid.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output logic ir_seen);
    a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b1;
    lat = 0;
    ir_seen = ir8;
    while (!ov8 && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!ov8) ir_seen = ir_seen | ir8;
    end
  endtask

  task automatic consume8();
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov8); end
    n_checks++; if (d8 !== 8'd0) begin n_fail++; $display("FAIL reset_diff got %0d want 0", d8); end
    n_checks++; if (bo8 !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", bo8); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'd200, 8'd5,  8'd0,   8'd255};
    logic [7:0] vb [4] = '{8'd55,  8'd10, 8'd0,   8'd254};
    logic       vi [4] = '{1'b0,   1'b0,  1'b1,   1'b1};
    logic [7:0] ed [4] = '{8'd145, 8'd251, 8'd255, 8'd0};
    logic       eb [4] = '{1'b0,   1'b1,  1'b1,   1'b0};
    int lat;
    logic irs;
    for (int i = 0; i < 4; i++) begin
      start8(va[i], vb[i], vi[i], lat, irs);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic%0d_latency got %0d want 8", i, lat); end
      n_checks++; if (irs !== 1'b0) begin n_fail++; $display("FAIL basic%0d_in_ready_busy got %b want 0", i, irs); end
      n_checks++; if (d8 !== ed[i]) begin n_fail++; $display("FAIL basic%0d_diff got %0d want %0d", i, d8, ed[i]); end
      n_checks++; if (bo8 !== eb[i]) begin n_fail++; $display("FAIL basic%0d_borrow got %b want %b", i, bo8, eb[i]); end
      consume8();
      n_checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin n_fail++; $display("FAIL basic%0d_release got ov=%b ir=%b want ov=0 ir=1", i, ov8, ir8); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic irs;
    start8(8'd100, 8'd30, 1'b0, lat, irs);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || d8 !== 8'd70 || bo8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d got ov=%b ir=%b diff=%0d bo=%b want ov=1 ir=0 diff=70 bo=0",
                 k, ov8, ir8, d8, bo8);
      end
      @(negedge clk);
    end
    consume8();
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", ov8); end
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", ir8); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic irs;
    start8(8'd5, 8'd10, 1'b0, lat, irs);
    consume8();
    a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || d8 !== 8'd0 || bo8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state got ov=%b ir=%b diff=%0d bo=%b want ov=0 ir=1 diff=0 bo=0",
               ov8, ir8, d8, bo8);
    end
    repeat (10) @(negedge clk);
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midreset_no_result got %b want 0", ov8); end
    start8(8'd3, 8'd1, 1'b0, lat, irs);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL midreset_latency got %0d want 8", lat); end
    n_checks++; if (d8 !== 8'd2 || bo8 !== 1'b0) begin n_fail++; $display("FAIL midreset_result got %0d/%b want 2/0", d8, bo8); end
    consume8();
  endtask

  task automatic test_n1();
    logic [0:0] va [2] = '{1'b0, 1'b1};
    logic [0:0] vb [2] = '{1'b1, 1'b0};
    logic       vi [2] = '{1'b0, 1'b1};
    logic [0:0] ed [2] = '{1'b1, 1'b0};
    logic       eb [2] = '{1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      a1 = va[i]; b1 = vb[i]; bin1 = vi[i]; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL n1_%0d_latency got %0d want 1", i, lat); end
      n_checks++; if (d1 !== ed[i] || bo1 !== eb[i]) begin n_fail++; $display("FAIL n1_%0d_result got %b/%b want %b/%b", i, d1, bo1, ed[i], eb[i]); end
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'd9, 8'd4, 8'd128};
    logic [7:0] vb [3] = '{8'd4, 8'd9, 8'd1};
    logic [7:0] ed [3] = '{8'd5, 8'd251, 8'd127};
    logic       eb [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] gd [3];
    logic       gb [3];
    int         gc [3];
    int         nxt = 0;
    int         got = 0;
    int         cyc;
`ifdef SERIAL_SUBTRACTOR_B2B_EN
    int         period = 9;
`else
    int         period = 10;
`endif
    or8 = 1'b1;
    bin8 = 1'b0;
    for (cyc = 0; cyc < 200 && got < 3; cyc++) begin
      if (ov8) begin
        gd[got] = d8; gb[got] = bo8; gc[got] = cyc;
        got++;
      end
      if (ir8) begin
        if (nxt < 3) begin
          a8 = va[nxt]; b8 = vb[nxt]; iv8 = 1'b1;
          nxt++;
        end else begin
          iv8 = 1'b0;
        end
      end
      @(negedge clk);
    end
    iv8 = 1'b0;
    or8 = 1'b0;
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (gd[i] !== ed[i] || gb[i] !== eb[i]) begin n_fail++; $display("FAIL b2b_result%0d got %0d/%b want %0d/%b", i, gd[i], gb[i], ed[i], eb[i]); end
      if (i > 0) begin
        n_checks++; if (gc[i] - gc[i-1] !== period) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, gc[i] - gc[i-1], period); end
      end
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_n1();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor_borrowing.md
# serial_subtractor_borrowing

Bit-serial subtractor with an N+1-bit result. It computes `{borrow_out, diff} = a - b - b_in` over `INPUT_SIZE` clock cycles, one bit per cycle, LSB first, using a single full-subtractor cell and a borrow flip-flop. It trades latency for area in the datapath next to the combinational ripple adders, and uses valid/ready handshakes on both the operand side and the result side.

## Interface
- `INPUT_SIZE`, default 8: operand width N; legal values are N ≥ 1.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  operands `a`, `b`, `b_in` are valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  N  minuend.
- `b`  input  N  subtrahend.
- `b_in`  input  1  borrow in.
- `out_valid`  output  1  `diff` and `borrow_out` are valid.
- `out_ready`  input  1  consumer accepts the result.
- `diff`  output  N  difference, modulo 2^N.
- `borrow_out`  output  1  set iff a < b + b_in (unsigned); this is bit N of the result.

## Operation
- Arithmetic: `{borrow_out, diff} = ({1'b0,a} - {1'b0,b} - b_in) mod 2^(N+1)`.
- Per-bit cell, with `br` the borrow register:
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
- States:
  - IDLE: `in_ready=1`, `out_valid=0`. On the input handshake (`in_valid & in_ready`), capture `a` and `b` into shift registers, load `br=b_in`, clear the bit counter, then go to BUSY.
  - BUSY: `in_ready=0`, `out_valid=0`.
    - Each cycle: compute `d_i` from the shift-register LSBs, shift `d_i` into `diff` from the MSB side, shift the operands right, update `br`, increment the counter.
    - After the N-th bit, go to DONE.
  - DONE: `out_valid=1`; `diff`/`borrow_out` are held stable until `out_ready`. On the output handshake, go to IDLE (see Configuration for the alternative).
- Inputs are ignored outside an input handshake. Operand changes during BUSY do not affect the result.
- `out_ready` is ignored outside DONE.
- The counter must be `$clog2(N)+1` bits so that N=1 works correctly.
- Reset, including mid-operation: state IDLE, `in_ready=1`, `out_valid=0`, `diff=0`, `borrow_out=0`, `br=0`, counter 0. Any operation in flight is discarded and no result is produced.

## Timing
- Input handshake at edge E0 → BUSY for edges E1..EN → `out_valid` is high in the cycle after EN. Latency is N cycles from accept to `out_valid`.
- Earliest output handshake is at edge EN+1.
- Throughput without the option: one result per N+2 cycles. IDLE is re-entered after EN+1, so the earliest next accept is at EN+2.
- `in_ready` depends only on state. It never depends combinationally on `in_valid`.
- `out_valid` is a registered state decode.
- Backpressure: `out_valid` stays high indefinitely while `out_ready=0`. `diff` and `borrow_out` must not change during that time.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_B2B_EN`.
- Defined:
  - In DONE, `in_ready = out_ready`.
  - Simultaneous output and input handshakes at one edge load the new operands and go directly to BUSY. `diff`/`borrow_out` then hold the previous result until they are overwritten by shifting.
  - `out_valid` drops.
  - Throughput is one result per N+1 cycles.
  - This path is combinational from `out_ready` to `in_ready`.
- Undefined:
  - `in_ready=0` in DONE.
  - DONE always returns to IDLE.
  - No combinational input-to-output paths.

## Test plan
- N=8: a=200, b=55, b_in=0 accepted at E0 → `out_valid` rises exactly 8 cycles later with diff=145, borrow_out=0; `in_ready` is low throughout BUSY/DONE.
- N=8: a=5, b=10, b_in=0 → diff=251, borrow_out=1. Also a=0, b=0, b_in=1 → diff=255, borrow_out=1, and a=255, b=254, b_in=1 → diff=0, borrow_out=0.
- N=8 backpressure: hold `out_ready=0` for 20 cycles after `out_valid` rises → result stable, `in_ready=0`. Then assert `out_ready` → `out_valid` falls next cycle and `in_ready` rises.
- Reset mid-operation: deassert `rst_n` for one cycle at BUSY bit 4 → next cycle IDLE, `out_valid=0`, `diff=0`, `borrow_out=0`. A new operation (a=3, b=1) then yields diff=2, borrow_out=0.
- N=1: a=0, b=1, b_in=0 → diff=1, borrow_out=1, one cycle after accept. Also a=1, b=0, b_in=1 → diff=0, borrow_out=0.
- With `SERIAL_SUBTRACTOR_B2B_EN`, N=8, `in_valid` and `out_ready` held high: the stream (9-4), (4-9), (128-1) gives results 5/0, 251/1, 127/0, with `out_valid` pulses exactly 9 cycles apart. Without the macro, the same stream pulses 10 cycles apart.
